// File: rtl/bf_pkg.sv
// Shared types for the Bellman-Ford run sequencer: FSM state, engine grant, memory-port bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Widths come from the Const.vh macros NODES, PRED_WIDTH, VERT_WIDTH; the defaults below
// apply only when the build does not supply them. Optional feature macro: BF_EARLY_EXIT_EN.
`ifndef NODES
`define NODES 4
`endif
`ifndef PRED_WIDTH
`define PRED_WIDTH 1
`endif
`ifndef VERT_WIDTH
`define VERT_WIDTH 15
`endif

package bf_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_RELAX     = 3'd2,
        S_RELAX_GAP = 3'd3,
        S_CYCLE     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        G_NONE  = 2'd0,
        G_INIT  = 2'd1,
        G_RELAX = 2'd2,
        G_CYCLE = 2'd3
    } grant_t;

    // One engine's view of the vertex and adjacency memories.
    typedef struct packed {
        logic [`PRED_WIDTH:0] vm_addr_a;
        logic [`PRED_WIDTH:0] vm_addr_b;
        logic [`VERT_WIDTH:0] vm_data_b;
        logic                 vm_we_b;
        logic [`PRED_WIDTH:0] adj_row;
        logic [`PRED_WIDTH:0] adj_col;
    } eng_bus_t;

    localparam eng_bus_t ENG_BUS_IDLE = '0;

    // Which engine owns the shared memory ports in a given state.
    function automatic grant_t state_grant(input state_t s);
        case (s)
            S_INIT:  return G_INIT;
            S_RELAX: return G_RELAX;
            S_CYCLE: return G_CYCLE;
            default: return G_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bf_mem_mux.sv
// Grant-indexed mux placing one engine's memory bundle onto the shared vertex/adjacency ports.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a non-granted engine is simply not seen, with no grant the ports read all-zero.
// Ports: grant_i selects; init/relax/cycle_bus_i are the engine bundles; mem_bus_o drives the memories.
module bf_mem_mux
    import bf_pkg::*;
(
    input  grant_t   grant_i,
    input  eng_bus_t init_bus_i,
    input  eng_bus_t relax_bus_i,
    input  eng_bus_t cycle_bus_i,
    output eng_bus_t mem_bus_o
);

    always_comb begin
        mem_bus_o = ENG_BUS_IDLE;
        case (grant_i)
            G_INIT:  mem_bus_o = init_bus_i;
            G_RELAX: mem_bus_o = relax_bus_i;
            G_CYCLE: mem_bus_o = cycle_bus_i;
            default: mem_bus_o = ENG_BUS_IDLE;
        endcase
    end

endmodule

// File: rtl/bf_sequencer.sv
// Sequences init -> MAX_PASSES relax passes -> negative-cycle check, holding idle engines in reset.
// Latency: start to INIT one cycle; each engine done level advances state on the next edge; done pulses one cycle.
// Backpressure: start is ignored outside IDLE; done levels of non-active engines are ignored.
// Ports: clk/reset (sync, active-high), start/busy/done/pass_cnt run control, *_reset engine holds,
// *_done engine completions, relax_changed, per-engine memory bundles in, shared vertmat/adjmat ports out.
// Optional: BF_EARLY_EXIT_EN ends the run after a relax pass that changed no vertex, skipping CYCLE.
module bf_sequencer
    import bf_pkg::*;
#(
    parameter int MAX_PASSES = `NODES - 1,
    parameter int PASS_W     = 8            // must satisfy MAX_PASSES < 2**PASS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [PASS_W-1:0]    pass_cnt,
    output logic                 init_reset,
    output logic                 relax_reset,
    output logic                 cycle_reset,
    input  logic                 init_done,
    input  logic                 relax_done,
    input  logic                 cycle_done,
    input  logic                 relax_changed,
    input  logic [`PRED_WIDTH:0] init_vm_addr_a,
    input  logic [`PRED_WIDTH:0] init_vm_addr_b,
    input  logic [`VERT_WIDTH:0] init_vm_data_b,
    input  logic                 init_vm_we_b,
    input  logic [`PRED_WIDTH:0] init_adj_row,
    input  logic [`PRED_WIDTH:0] init_adj_col,
    input  logic [`PRED_WIDTH:0] relax_vm_addr_a,
    input  logic [`PRED_WIDTH:0] relax_vm_addr_b,
    input  logic [`VERT_WIDTH:0] relax_vm_data_b,
    input  logic                 relax_vm_we_b,
    input  logic [`PRED_WIDTH:0] relax_adj_row,
    input  logic [`PRED_WIDTH:0] relax_adj_col,
    input  logic [`PRED_WIDTH:0] cycle_vm_addr_a,
    input  logic [`PRED_WIDTH:0] cycle_vm_addr_b,
    input  logic [`VERT_WIDTH:0] cycle_vm_data_b,
    input  logic                 cycle_vm_we_b,
    input  logic [`PRED_WIDTH:0] cycle_adj_row,
    input  logic [`PRED_WIDTH:0] cycle_adj_col,
    output logic [`PRED_WIDTH:0] vertmat_addr_a,
    output logic [`PRED_WIDTH:0] vertmat_addr_b,
    output logic [`VERT_WIDTH:0] vertmat_data_b,
    output logic                 vertmat_we_b,
    output logic [`PRED_WIDTH:0] adjmat_row_addr,
    output logic [`PRED_WIDTH:0] adjmat_col_addr
);

    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(MAX_PASSES);
    localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);

    state_t            state_q, state_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic              init_reset_q, relax_reset_q, cycle_reset_q;
    grant_t            grant;
    eng_bus_t          init_bus, relax_bus, cycle_bus, mem_bus;

`ifdef BF_EARLY_EXIT_EN
    // relax_changed as it stood when the most recent pass completed.
    logic changed_q, changed_d;
`else
    logic unused_relax_changed;
    assign unused_relax_changed = relax_changed;
`endif

    // State register. Holds are registered from the next state, so a hold is low exactly
    // while the FSM sits in that engine's state and is high for at least one cycle before each run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pass_cnt_q    <= '0;
            init_reset_q  <= 1'b1;
            relax_reset_q <= 1'b1;
            cycle_reset_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            pass_cnt_q    <= pass_cnt_d;
            init_reset_q  <= (state_d != S_INIT);
            relax_reset_q <= (state_d != S_RELAX);
            cycle_reset_q <= (state_d != S_CYCLE);
        end
    end

`ifdef BF_EARLY_EXIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            changed_q <= 1'b1;
        end else begin
            changed_q <= changed_d;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
`ifdef BF_EARLY_EXIT_EN
        changed_d  = changed_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_INIT;
                    pass_cnt_d = '0;
                end
            end
            S_INIT: begin
                if (init_done) begin
                    state_d = S_RELAX;
                end
            end
            S_RELAX: begin
                if (relax_done) begin
                    state_d    = S_RELAX_GAP;
                    pass_cnt_d = pass_cnt_q + PASS_ONE;
`ifdef BF_EARLY_EXIT_EN
                    changed_d  = relax_changed;
`endif
                end
            end
            S_RELAX_GAP: begin
`ifdef BF_EARLY_EXIT_EN
                // A pass with no update means distances have converged: no negative cycle exists.
                if (!changed_q) begin
                    state_d = S_DONE;
                end else if (pass_cnt_q == PASS_LAST) begin
                    state_d = S_CYCLE;
                end else begin
                    state_d = S_RELAX;
                end
`else
                if (pass_cnt_q == PASS_LAST) begin
                    state_d = S_CYCLE;
                end else begin
                    state_d = S_RELAX;
                end
`endif
            end
            S_CYCLE: begin
                if (cycle_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        done  = (state_q == S_DONE);
        busy  = (state_q != S_IDLE) && (state_q != S_DONE);
        grant = state_grant(state_q);
    end

    assign pass_cnt    = pass_cnt_q;
    assign init_reset  = init_reset_q;
    assign relax_reset = relax_reset_q;
    assign cycle_reset = cycle_reset_q;

    assign init_bus  = '{init_vm_addr_a, init_vm_addr_b, init_vm_data_b,
                         init_vm_we_b, init_adj_row, init_adj_col};
    assign relax_bus = '{relax_vm_addr_a, relax_vm_addr_b, relax_vm_data_b,
                         relax_vm_we_b, relax_adj_row, relax_adj_col};
    assign cycle_bus = '{cycle_vm_addr_a, cycle_vm_addr_b, cycle_vm_data_b,
                         cycle_vm_we_b, cycle_adj_row, cycle_adj_col};

    bf_mem_mux u_mem_mux (
        .grant_i     (grant),
        .init_bus_i  (init_bus),
        .relax_bus_i (relax_bus),
        .cycle_bus_i (cycle_bus),
        .mem_bus_o   (mem_bus)
    );

    assign vertmat_addr_a  = mem_bus.vm_addr_a;
    assign vertmat_addr_b  = mem_bus.vm_addr_b;
    assign vertmat_data_b  = mem_bus.vm_data_b;
    assign vertmat_we_b    = mem_bus.vm_we_b;
    assign adjmat_row_addr = mem_bus.adj_row;
    assign adjmat_col_addr = mem_bus.adj_col;

endmodule

// File: tb/tb_bf_sequencer.sv
// Directed bench for bf_sequencer with behavioural engines that finish a fixed time after release.
// Latency: n/a.
// Backpressure: n/a.
`ifndef NODES
`define NODES 4
`endif
`ifndef PRED_WIDTH
`define PRED_WIDTH 1
`endif
`ifndef VERT_WIDTH
`define VERT_WIDTH 15
`endif

module tb_bf_sequencer;

    localparam int AW = `PRED_WIDTH + 1;
    localparam int DW = `VERT_WIDTH + 1;
    localparam int NPASS = `NODES - 1;
    localparam int ENG_DLY = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start;
    logic          busy, done;
    logic [7:0]    pass_cnt;
    logic          init_reset, relax_reset, cycle_reset;
    logic          init_done, relax_done, cycle_done, relax_changed;
    logic [AW-1:0] i_aa, i_ab, i_row, i_col, r_aa, r_ab, r_row, r_col, c_aa, c_ab, c_row, c_col;
    logic [DW-1:0] i_db, r_db, c_db;
    logic          i_we, r_we, c_we;
    logic [AW-1:0] vm_aa, vm_ab, adj_row, adj_col;
    logic [DW-1:0] vm_db;
    logic          vm_we;

    // Behavioural engines: done rises ENG_DLY edges after the hold is released.
    logic [3:0] icnt = '0, rcnt = '0, ccnt = '0;
    logic       force_cdone;
    always @(posedge clk) begin
        icnt <= init_reset  ? 4'd0 : (icnt == 4'd15 ? icnt : icnt + 4'd1);
        rcnt <= relax_reset ? 4'd0 : (rcnt == 4'd15 ? rcnt : rcnt + 4'd1);
        ccnt <= cycle_reset ? 4'd0 : (ccnt == 4'd15 ? ccnt : ccnt + 4'd1);
    end
    assign init_done  = !init_reset  && (int'(icnt) >= ENG_DLY);
    assign relax_done = !relax_reset && (int'(rcnt) >= ENG_DLY);
    assign cycle_done = force_cdone | (!cycle_reset && (int'(ccnt) >= ENG_DLY));

    bf_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass_cnt(pass_cnt),
        .init_reset(init_reset), .relax_reset(relax_reset), .cycle_reset(cycle_reset),
        .init_done(init_done), .relax_done(relax_done), .cycle_done(cycle_done),
        .relax_changed(relax_changed),
        .init_vm_addr_a(i_aa), .init_vm_addr_b(i_ab), .init_vm_data_b(i_db), .init_vm_we_b(i_we),
        .init_adj_row(i_row), .init_adj_col(i_col),
        .relax_vm_addr_a(r_aa), .relax_vm_addr_b(r_ab), .relax_vm_data_b(r_db), .relax_vm_we_b(r_we),
        .relax_adj_row(r_row), .relax_adj_col(r_col),
        .cycle_vm_addr_a(c_aa), .cycle_vm_addr_b(c_ab), .cycle_vm_data_b(c_db), .cycle_vm_we_b(c_we),
        .cycle_adj_row(c_row), .cycle_adj_col(c_col),
        .vertmat_addr_a(vm_aa), .vertmat_addr_b(vm_ab), .vertmat_data_b(vm_db), .vertmat_we_b(vm_we),
        .adjmat_row_addr(adj_row), .adjmat_col_addr(adj_col)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                                         input logic [DW-1:0] db, input logic we,
                                         input logic [AW-1:0] row, input logic [AW-1:0] col);
        return 64'({aa, ab, db, we, row, col});
    endfunction

    // Scoreboard: one entry per accepted start, popped at the done pulse.
    typedef struct {
        int passes;
        int cyc;
        int clen;
    } exp_t;
    exp_t sb[$];

    int   ri = 0, rr = 0, rc = 0, clen = 0, ndone = 0;
    logic pi = 1'b1, pr = 1'b1, pc = 1'b1, pdone = 1'b0;

    always begin
        logic [63:0] expb;
        int lows;
        exp_t e;
        @(posedge clk);
        #1;
        if (reset) begin
            ri = 0; rr = 0; rc = 0; clen = 0;
            pi = 1'b1; pr = 1'b1; pc = 1'b1; pdone = 1'b0;
        end else begin
            if (!init_reset  && pi) ri++;
            if (!relax_reset && pr) rr++;
            if (!cycle_reset && pc) rc++;
            if (!cycle_reset) clen++;
            lows = int'(!init_reset) + int'(!relax_reset) + int'(!cycle_reset);
            chk("single_grant", 64'(lows <= 1), 64'd1);
            // The engine whose hold is low must own the ports; otherwise they read zero.
            if (!init_reset)       expb = pack(i_aa, i_ab, i_db, i_we, i_row, i_col);
            else if (!relax_reset) expb = pack(r_aa, r_ab, r_db, r_we, r_row, r_col);
            else if (!cycle_reset) expb = pack(c_aa, c_ab, c_db, c_we, c_row, c_col);
            else                   expb = '0;
            chk("mem_mux", pack(vm_aa, vm_ab, vm_db, vm_we, adj_row, adj_col), expb);
            if (done) begin
                chk("done_one_cycle", 64'(pdone), 64'd0);
                chk("busy_at_done", 64'(busy), 64'd0);
                chk("done_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("final_pass_cnt", 64'(pass_cnt), 64'(e.passes));
                    chk("relax_runs", 64'(rr), 64'(e.passes));
                    chk("init_runs", 64'(ri), 64'd1);
                    chk("cycle_runs", 64'(rc), 64'(e.cyc));
                    chk("cycle_len", 64'(clen), 64'(e.clen));
                end
                ndone++;
                ri = 0; rr = 0; rc = 0; clen = 0;
            end
            pi = init_reset; pr = relax_reset; pc = cycle_reset; pdone = done;
        end
    end

    task automatic wait_runs(input int target, input int budget);
        int k = 0;
        while (ndone < target && k < budget) begin
            @(negedge clk);
            r_db = DW'($urandom);
            k++;
        end
        chk("run_complete", 64'(ndone), 64'(target));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; relax_changed = 1'b1; force_cdone = 1'b0;
        i_aa = AW'(1); i_ab = AW'(2); i_db = DW'(16'h1111); i_we = 1'b1; i_row = AW'(1); i_col = AW'(2);
        r_aa = AW'(3); r_ab = AW'(1); r_db = DW'(16'h2222); r_we = 1'b0; r_row = AW'(2); r_col = AW'(3);
        c_aa = AW'(2); c_ab = AW'(3); c_db = DW'(16'h3333); c_we = 1'b1; c_row = AW'(3); c_col = AW'(1);
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_pass_cnt", 64'(pass_cnt), 64'd0);
        chk("reset_holds", 64'({init_reset, relax_reset, cycle_reset}), 64'h7);
        reset = 1'b0;
        @(negedge clk);

        // Normal run: init, NPASS relax passes, cycle check.
        sb.push_back('{NPASS, 1, ENG_DLY + 1});
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_runs(1, 300);
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("pass_cnt_held", 64'(pass_cnt), 64'(NPASS));
        chk("idle_holds", 64'({init_reset, relax_reset, cycle_reset}), 64'h7);

        // First pass reports no change.
        relax_changed = 1'b0;
`ifdef BF_EARLY_EXIT_EN
        sb.push_back('{1, 0, 0});
`else
        sb.push_back('{NPASS, 1, ENG_DLY + 1});
`endif
        pulse_start();
        wait_runs(2, 300);
        relax_changed = 1'b1;
        @(negedge clk);

        // Reset in the middle of pass 2 abandons the run.
        sb.push_back('{NPASS, 1, ENG_DLY + 1});
        pulse_start();
        k = 0;
        while (rr < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reached_pass2", 64'(rr), 64'd2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_holds", 64'({init_reset, relax_reset, cycle_reset}), 64'h7);
        chk("midrst_pass_cnt", 64'(pass_cnt), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_ports", 64'({vm_we, vm_aa, vm_ab, vm_db, adj_row, adj_col}), 64'd0);
        sb.delete();
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_done_after_reset", 64'(ndone), 64'd2);
        sb.push_back('{NPASS, 1, ENG_DLY + 1});
        pulse_start();
        wait_runs(3, 300);
        @(negedge clk);

        // start coincident with reset is dropped.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_start_busy", 64'(busy), 64'd0);
        chk("rst_start_holds", 64'({init_reset, relax_reset, cycle_reset}), 64'h7);
        chk("rst_start_runs", 64'(ndone), 64'd3);

        // start held high through the whole run gives exactly one run.
        sb.push_back('{NPASS, 1, ENG_DLY + 1});
        start = 1'b1;
        wait_runs(4, 300);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("held_start_runs", 64'(ndone), 64'd4);
        chk("held_start_busy", 64'(busy), 64'd0);

        // cycle_done already high on entry: one-cycle CYCLE, and ignored elsewhere.
        force_cdone = 1'b1;
        sb.push_back('{NPASS, 1, 1});
        pulse_start();
        wait_runs(5, 300);
        force_cdone = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
